// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dispatch: up to N pushes and
// N pops per cycle, oldest N entries shown combinationally, cleared on flush.
module inst_buffer #(
  parameter int  N             = 3,
  parameter int  DEPTH         = 16,
  parameter type inst_packet_t = logic [64:0]
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  inst_packet_t [N-1:0]          in_insts,
  input  logic [$clog2(N+1)-1:0]        num_in,
  input  logic [$clog2(N+1)-1:0]        num_dispatch,
  output inst_packet_t [N-1:0]          out_insts,
  output logic [$clog2(N+1)-1:0]        num_valid_out,
  output logic [$clog2(N+1)-1:0]        num_accepted,
  output logic [$clog2(DEPTH+1)-1:0]    num_free,
  output logic                          full,
  output logic                          empty
);

  localparam int CW = $clog2(N+1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  inst_packet_t  mem [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [FW-1:0] count_q;
  logic [FW-1:0] valid_w, free_w, accept_w;
  logic [CW-1:0] pops;

  // Count-based handshake: fetch offers num_in lanes and learns num_accepted in
  // the same cycle; dispatch sees num_valid_out lanes and returns num_dispatch.
  // Room for pushes comes from registered count only, so pops never feed fetch.
  always_comb begin
    valid_w = (count_q > FW'(N)) ? FW'(N) : count_q;
    free_w  = FW'(DEPTH) - count_q;
    if (flush)
      accept_w = '0;
    else if (FW'(num_in) > free_w)
      accept_w = free_w;
    else
      accept_w = FW'(num_in);
    if (flush)
      pops = '0;
    else if (FW'(num_dispatch) > valid_w)
      pops = CW'(valid_w);
    else
      pops = num_dispatch;
  end

  assign num_valid_out = CW'(valid_w);
  assign num_accepted  = CW'(accept_w);
  assign num_free      = free_w;
  assign full          = (count_q == FW'(DEPTH));
  assign empty         = (count_q == '0);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (i < int'(valid_w))
        out_insts[i] = mem[head_q + PW'(i)];
      else
        out_insts[i] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pops);
      tail_q  <= tail_q + PW'(accept_w);
      count_q <= count_q + accept_w - FW'(pops);
    end
  end

  // Storage is not reset; only entries behind head..tail are ever presented.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < num_accepted)
        mem[tail_q + PW'(i)] <= in_insts[i];
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer (N=3, DEPTH=8): directed test-plan sequence followed by
// random traffic, checked against a queue model through an expected queue.
module tb_inst_buffer;

  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(N+1);
  localparam int FW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);
  localparam int OW    = N*PKT_W + 2*CW + FW + 2;

  logic            clock, reset, flush;
  pkt_t [N-1:0]    in_insts, out_insts;
  logic [CW-1:0]   num_in, num_dispatch, num_valid_out, num_accepted;
  logic [FW-1:0]   num_free;
  logic            full, empty;

  logic [OW-1:0]   exp_q[$];
  pkt_t            model_q[$];
  int              vectors, miscompares;
  int              next_pc;

  inst_buffer #(.N(N), .DEPTH(DEPTH), .inst_packet_t(pkt_t)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_insts(in_insts), .num_in(num_in), .num_dispatch(num_dispatch),
    .out_insts(out_insts), .num_valid_out(num_valid_out),
    .num_accepted(num_accepted), .num_free(num_free),
    .full(full), .empty(empty)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OW-1:0] observed();
    return {out_insts, num_valid_out, num_accepted, num_free, full, empty};
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model view: what the outputs must be given the queued entries.
  function automatic logic [OW-1:0] expected(input logic f, input int ni);
    pkt_t [N-1:0] lanes;
    int sz, nvo, free_n, acc;
    lanes  = '0;
    sz     = model_q.size();
    nvo    = min2(sz, N);
    free_n = DEPTH - sz;
    acc    = f ? 0 : min2(ni, free_n);
    for (int i = 0; i < nvo; i++) lanes[i] = model_q[i];
    return {lanes, CW'(nvo), CW'(acc), FW'(free_n), (sz == DEPTH), (sz == 0)};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
    end
  endtask

  task automatic check_idle(input string name);
    logic [OW-1:0] idle;
    idle = {{(N*PKT_W){1'b0}}, CW'(0), CW'(0), FW'(DEPTH), 1'b0, 1'b1};
    check(name, observed(), idle);
  endtask

  // Driver: one cycle of fetch/dispatch/flush activity, starting just after a posedge.
  task automatic drive(input logic f, input int ni, input int nd);
    int nvo, acc;
    nvo = min2(model_q.size(), N);
    acc = f ? 0 : min2(ni, DEPTH - model_q.size());
    assert (nd <= nvo) else $error("protocol: num_dispatch %0d > num_valid_out %0d", nd, nvo);
    for (int i = 0; i < N; i++) begin
      in_insts[i].valid = (i < ni) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
      in_insts[i].pc    = 32'(next_pc + i);
      in_insts[i].inst  = $urandom;
    end
    flush        = f;
    num_in       = CW'(ni);
    num_dispatch = CW'(nd);
    exp_q.push_back(expected(f, ni));
    @(posedge clock);
    if (f) begin
      model_q.delete();
    end else begin
      for (int j = 0; j < nd; j++) void'(model_q.pop_front());
      for (int i = 0; i < acc; i++) model_q.push_back(in_insts[i]);
      next_pc += acc;
    end
    #1;
    flush        = 1'b0;
    num_in       = '0;
    num_dispatch = '0;
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) check("cycle", observed(), exp_q.pop_front());
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    next_pc      = 0;
    flush        = 1'b0;
    num_in       = '0;
    num_dispatch = '0;
    in_insts     = '0;
    reset        = 1'b1;
    #1 reset = 1'b0;
    #2 check_idle("reset_initial");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Fill to full, then rejected push
    drive(0, 3, 0); drive(0, 3, 0); drive(0, 3, 0); drive(0, 3, 0);
    // Pop on full with push rejected, then lane0 = entry 2
    drive(0, 3, 2); drive(0, 0, 0);
    // Wrap-around: head to 6 with count 4, then pop 3
    drive(0, 0, 3); drive(0, 0, 1); drive(0, 2, 0); drive(0, 0, 3); drive(0, 0, 0);
    // Flush at count 5 with traffic, then first push after flush
    drive(0, 3, 0); drive(0, 1, 0); drive(1, 3, 2); drive(0, 3, 0); drive(0, 0, 0);
    // Empty bypass latency and partial dispatch
    drive(1, 0, 0); drive(0, 2, 0); drive(0, 0, 1); drive(0, 0, 0);

    // Asynchronous reset mid-stream at count 5, off the clock edge
    drive(0, 3, 0); drive(0, 1, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_idle("reset_midstream");
    model_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    drive(0, 0, 0);

    // Random traffic
    repeat (400) begin
      logic f;
      int   ni, nd;
      f  = ($urandom_range(0, 24) == 0);
      ni = $urandom_range(0, N);
      nd = $urandom_range(0, min2(model_q.size(), N));
      drive(f, ni, nd);
    end

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
